// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Control unit for a multicycle RV32 subset datapath (lw, sw, R-type, I-ALU, beq).
// Every instruction walks FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK,
// so PC enable and write strobes fire at most once per instruction.
// An illegal opcode or an unsupported funct3 parks the FSM in TRAP until reset.
//
// Parameters:
//   MEM_WAIT  cycles spent in MEMORY (1..15)
//   CNT_W     width of the memory wait counter
//
// Ports:
//   CLK, RESET              clock (rising edge), synchronous active-low reset
//   OP, funct3, funct7      instruction fields from the datapath (sampled in DECODE)
//   Zero                    ALU zero flag (selects the branch target for beq)
//   EN                      PC update enable, one pulse per retired instruction
//   PCSrc, ResultSrc,
//   ALUSrc, ImmSrc,
//   ALUControl              datapath mux / ALU controls
//   MemWrite, RegWrite      write strobes
//   Trap                    sticky illegal-instruction flag
//   InstrRet                retired-instruction count (only with CTRL_PERF_CNT_EN)
//   dbg_state               current FSM state encoding
//
// Build option: define CTRL_PERF_CNT_EN to add the 32-bit InstrRet counter.
//
// Handshake note: there is no valid/ready handshake; the datapath is assumed to
// follow the control outputs every cycle and the FSM never stalls on it.
module multicycle_control_fsm #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  OP,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic        Zero,
  output logic        EN,
  output logic        PCSrc,
  output logic        ResultSrc,
  output logic        ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [2:0]  ALUControl,
  output logic        Trap,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] InstrRet,
`endif
  output logic [2:0]  dbg_state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic [2:0]         f3_q, f3_d;
  logic               f7_q, f7_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic en_q, en_d, pc_src_q, pc_src_d, result_src_q, result_src_d;
  logic alu_src_q, alu_src_d, mem_write_q, mem_write_d, reg_write_q, reg_write_d;
  logic trap_q, trap_d;
  logic [1:0] imm_src_q, imm_src_d;
  logic [2:0] alu_ctrl_q, alu_ctrl_d;

  logic is_lw, is_sw, is_r, is_i, is_beq, ctrl_valid, legal_in;

  // R-type and I-ALU only support funct3 000/010/110/111.
  always_comb begin
    legal_in = 1'b0;
    case (OP)
      OP_LW, OP_SW, OP_BEQ: legal_in = 1'b1;
      OP_R, OP_I: legal_in = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                             (funct3 == 3'b110) || (funct3 == 3'b111);
      default: legal_in = 1'b0;
    endcase
  end

  // Next-state and field latching.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d    = OP;
        f3_d    = funct3;
        f7_d    = funct7;
        state_d = legal_in ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEMORY;
          cnt_d   = CNT_W'(MEM_WAIT - 1);
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (cnt_q == '0) state_d = S_WRITEBACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the *next* state and fields, then registered,
  // so each output flop lines up with the state it belongs to.
  always_comb begin
    is_lw      = (op_d == OP_LW);
    is_sw      = (op_d == OP_SW);
    is_r       = (op_d == OP_R);
    is_i       = (op_d == OP_I);
    is_beq     = (op_d == OP_BEQ);
    ctrl_valid = (state_d == S_EXECUTE) || (state_d == S_MEMORY) ||
                 (state_d == S_WRITEBACK);

    alu_src_d    = ctrl_valid && (is_lw || is_sw || is_i);
    result_src_d = ctrl_valid && is_lw;
    imm_src_d    = 2'b00;
    alu_ctrl_d   = 3'b000;
    if (ctrl_valid) begin
      if (is_sw)  imm_src_d = 2'b01;
      if (is_beq) imm_src_d = 2'b10;
      if (is_beq) alu_ctrl_d = 3'b001;
      if (is_r || is_i) begin
        case (f3_d)
          3'b000:  alu_ctrl_d = (is_r && f7_d) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl_d = 3'b101;
          3'b110:  alu_ctrl_d = 3'b011;
          3'b111:  alu_ctrl_d = 3'b010;
          default: alu_ctrl_d = 3'b000;
        endcase
      end
    end

    mem_write_d = (state_d == S_MEMORY) && (cnt_d == '0) && is_sw;
    en_d        = (state_d == S_WRITEBACK);
    reg_write_d = (state_d == S_WRITEBACK) && (is_r || is_i || is_lw);
    pc_src_d    = (state_d == S_WRITEBACK) && is_beq && Zero;
    trap_d      = (state_d == S_TRAP);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      f3_q         <= '0;
      f7_q         <= 1'b0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      pc_src_q     <= 1'b0;
      result_src_q <= 1'b0;
      alu_src_q    <= 1'b0;
      imm_src_q    <= 2'b00;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_ctrl_q   <= 3'b000;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      f3_q         <= f3_d;
      f7_q         <= f7_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      pc_src_q     <= pc_src_d;
      result_src_q <= result_src_d;
      alu_src_q    <= alu_src_d;
      imm_src_q    <= imm_src_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      alu_ctrl_q   <= alu_ctrl_d;
      trap_q       <= trap_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Counts each EN cycle; wraps naturally at 32 bits. EN is never high in
  // TRAP, so the count holds there.
  logic [31:0] instr_ret_q, instr_ret_d;

  always_comb begin
    instr_ret_d = instr_ret_q + {31'b0, en_q};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) instr_ret_q <= '0;
    else        instr_ret_q <= instr_ret_d;
  end

  assign InstrRet = instr_ret_q;
`endif

  assign EN         = en_q;
  assign PCSrc      = pc_src_q;
  assign ResultSrc  = result_src_q;
  assign ALUSrc     = alu_src_q;
  assign ImmSrc     = imm_src_q;
  assign MemWrite   = mem_write_q;
  assign RegWrite   = reg_write_q;
  assign ALUControl = alu_ctrl_q;
  assign Trap       = trap_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm (MEM_WAIT = 3).
// Expected per-cycle output vectors come from a small instruction model and
// are queued when an instruction is driven; each scenario pops and compares
// one vector per cycle at the falling clock edge.
module tb_multicycle_control_fsm;

  localparam int MEM_WAIT = 3;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic [6:0] OP = '0;
  logic [2:0] funct3 = '0;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0;
  logic       EN, PCSrc, ResultSrc, ALUSrc, MemWrite, RegWrite, Trap;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl, dbg_state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] InstrRet;
`endif

  multicycle_control_fsm #(.MEM_WAIT(MEM_WAIT), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .EN(EN), .PCSrc(PCSrc), .ResultSrc(ResultSrc),
    .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .Trap(Trap),
`ifdef CTRL_PERF_CNT_EN
    .InstrRet(InstrRet),
`endif
    .dbg_state(dbg_state)
  );

  // Observed vector: {EN, PCSrc, ResultSrc, ALUSrc, ImmSrc, MemWrite, RegWrite, ALUControl, Trap}
  logic [12:0] obs;
  assign obs = {EN, PCSrc, ResultSrc, ALUSrc, ImmSrc, MemWrite, RegWrite, ALUControl, Trap};

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  logic [12:0] exp_v;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [12:0] vec(input logic en, input logic pcs, input logic rs,
                                      input logic as, input logic [1:0] imm,
                                      input logic mw, input logic rw,
                                      input logic [2:0] alu, input logic tr);
    return {en, pcs, rs, as, imm, mw, rw, alu, tr};
  endfunction

  // Instruction model: pushes one expected vector per cycle, starting at FETCH.
  task automatic push_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z);
    logic legal, is_mem, is_sw, is_beq, wr, as, rs;
    logic [1:0] imm;
    logic [2:0] alu;
    logic [12:0] st;
    legal = 1'b1; is_mem = 1'b0; is_sw = 1'b0; is_beq = 1'b0;
    wr = 1'b0; as = 1'b0; rs = 1'b0; imm = 2'b00; alu = 3'b000;
    case (op)
      7'b0000011: begin is_mem = 1'b1; wr = 1'b1; as = 1'b1; rs = 1'b1; end
      7'b0100011: begin is_mem = 1'b1; is_sw = 1'b1; as = 1'b1; imm = 2'b01; end
      7'b1100011: begin is_beq = 1'b1; imm = 2'b10; alu = 3'b001; end
      7'b0110011, 7'b0010011: begin
        wr = 1'b1;
        as = (op == 7'b0010011);
        case (f3)
          3'b000:  alu = (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
          3'b010:  alu = 3'b101;
          3'b110:  alu = 3'b011;
          3'b111:  alu = 3'b010;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    exp_q.push_back(13'd0);  // FETCH
    exp_q.push_back(13'd0);  // DECODE
    if (!legal) begin
      for (int i = 0; i < 20; i++)
        exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1));
      return;
    end
    st = vec(1'b0, 1'b0, rs, as, imm, 1'b0, 1'b0, alu, 1'b0);
    exp_q.push_back(st);     // EXECUTE
    if (is_mem)
      for (int i = 0; i < MEM_WAIT; i++)
        exp_q.push_back(st | vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                 is_sw && (i == MEM_WAIT - 1), 1'b0, 3'b000, 1'b0));
    exp_q.push_back(st | vec(1'b1, is_beq & z, 1'b0, 1'b0, 2'b00, 1'b0, wr, 3'b000, 1'b0));
  endtask

  // ---------------- driver tasks ----------------
  // Called at the falling edge of a FETCH cycle.
  task automatic drive_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z);
    OP = op; funct3 = f3; funct7 = f7; Zero = z;
    push_instr(op, f3, f7, z);
  endtask

  // Garbage on the instruction fields once DECODE has latched them.
  task automatic scramble();
    OP     = 7'($urandom_range(0, 127));
    funct3 = 3'($urandom_range(0, 7));
    funct7 = 1'($urandom_range(0, 1));
  endtask

  task automatic pick_legal(output logic [6:0] op, output logic [2:0] f3, output logic f7);
    logic [2:0] f3_tab [4];
    logic [6:0] op_tab [5];
    f3_tab = '{3'b000, 3'b010, 3'b110, 3'b111};
    op_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
    op = op_tab[$urandom_range(0, 4)];
    f3 = f3_tab[$urandom_range(0, 3)];
    f7 = 1'($urandom_range(0, 1));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if (obs !== 13'd0 || dbg_state !== 3'd0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got outputs %b state %0d, expected %b state 0",
                 c, obs, dbg_state, 13'd0);
      end
    end
    RESET = 1'b1;
  endtask

  task automatic test_r_sub();
    int c;
    drive_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    c = 1;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL r_sub cycle %0d: got %b, expected %b", c, obs, exp_v);
      end
      @(negedge CLK); c++;
      if (c >= 3) scramble();
    end
  endtask

  task automatic test_mem(input logic [6:0] op);
    int c;
    drive_instr(op, 3'b010, 1'b0, 1'b0);
    c = 1;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mem op=%b cycle %0d: got %b, expected %b", op, c, obs, exp_v);
      end
      @(negedge CLK); c++;
      if (c >= 3) scramble();
    end
  endtask

  task automatic test_beq();
    int c;
    for (int r = 0; r < 2; r++) begin
      drive_instr(7'b1100011, 3'b000, 1'b0, (r == 0));
      c = 1;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL beq zero=%0d cycle %0d: got %b, expected %b", Zero, c, obs, exp_v);
        end
        @(negedge CLK); c++;
        if (c >= 3) scramble();
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0] f3_tab [4];
    int c;
    f3_tab = '{3'b000, 3'b010, 3'b110, 3'b111};
    for (int k = 0; k < 8; k++) begin
      drive_instr((k < 4) ? 7'b0110011 : 7'b0010011, f3_tab[k % 4],
                  1'($urandom_range(0, 1)), 1'b0);
      c = 1;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL alu_op %0d cycle %0d: got %b, expected %b", k, c, obs, exp_v);
        end
        @(negedge CLK); c++;
        if (c >= 3) scramble();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    int c;
    for (int k = 0; k < 12; k++) begin
      pick_legal(op, f3, f7);
      drive_instr(op, f3, f7, 1'($urandom_range(0, 1)));
      c = 1;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL b2b instr %0d op=%b cycle %0d: got %b, expected %b", k, op, c, obs, exp_v);
        end
        @(negedge CLK); c++;
        if (c >= 3) scramble();
      end
    end
  endtask

  // Illegal opcode, then an R-type with unsupported funct3; each recovers by reset.
  task automatic test_trap();
    logic [6:0] ops [2];
    logic [2:0] f3s [2];
    int c;
    ops = '{7'b1111111, 7'b0110011};
    f3s = '{3'b000, 3'b001};
    for (int t = 0; t < 2; t++) begin
      drive_instr(ops[t], f3s[t], 1'b0, 1'b0);
      c = 1;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL trap %0d cycle %0d: got %b, expected %b", t, c, obs, exp_v);
        end
        @(negedge CLK); c++;
        if (c >= 3) scramble();
      end
      n_checks++;
      if (dbg_state !== 3'd5 || Trap !== 1'b1) begin
        n_fail++;
        $display("FAIL trap %0d sticky: got state %0d Trap %b, expected state 5 Trap 1",
                 t, dbg_state, Trap);
      end
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      n_checks++;
      if (obs !== 13'd0 || dbg_state !== 3'd0) begin
        n_fail++;
        $display("FAIL trap %0d reset: got %b state %0d, expected %b state 0",
                 t, obs, dbg_state, 13'd0);
      end
    end
  endtask

  // Reset during the first MEMORY cycle of sw must abort without strobes.
  task automatic test_reset_mid_mem();
    drive_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mid_mem cycle %0d: got %b, expected %b", c, obs, exp_v);
      end
      if (c < 4) @(negedge CLK);
    end
    exp_q.delete();
    RESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (c == 2) RESET = 1'b1;
      n_checks++;
      if (obs !== 13'd0 || dbg_state !== 3'd0) begin
        n_fail++;
        $display("FAIL mid_mem abort %0d: got %b state %0d, expected %b state 0",
                 c, obs, dbg_state, 13'd0);
      end
    end
    test_r_sub();
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf();
    int c;
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL perf add %0d: got %b, expected %b", k, obs, exp_v);
        end
        @(negedge CLK);
      end
    end
    n_checks++;
    if (InstrRet !== 32'd5) begin
      n_fail++;
      $display("FAIL perf count: got %0d, expected 5", InstrRet);
    end
    drive_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    c = 0;
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      @(negedge CLK); c++;
    end
    n_checks++;
    if (InstrRet !== 32'd5 || Trap !== 1'b1) begin
      n_fail++;
      $display("FAIL perf trap hold: got %0d Trap %b after %0d cycles, expected 5 Trap 1",
               InstrRet, Trap, c);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_r_sub();
    test_mem(7'b0000011);
    test_mem(7'b0100011);
    test_beq();
    test_alu_ops();
    test_back_to_back();
    test_trap();
    test_reset_mid_mem();
`ifdef CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
